serial_paralelo: RTL and testbench
==================================

// Module: serial_paralelo
// PURPOSE
//  Receive-side deserializer; sits directly downstream of the parallel-to-serial emitter.
//  Samples the 1-bit serial line one bit per clk and finds the K28.5 comma to set word alignment.
//  Re-packs the stream into aligned 10-bit words, each marked by a one-cycle valid strobe.
//  Declares lock after COMMA_LOCK consecutive aligned commas.
// PARAMETERS
//  COMMA_P     10'b0011111010  K28.5, RD- form (first-received bit = [9])
//  COMMA_N     10'b1100000101  K28.5, RD+ form
//  COMMA_LOCK  3               aligned commas in a row needed to enter LOCKED (1..7)
//  LOS_THRESH  2               misaligned commas in LOCKED before loss of sync (SP_LOS_EN only)
// PORTS
//  clk           in   1   bit clock; all logic on posedge
//  rst           in   1   asynchronous reset, active-low
//  enb           in   1   enable; 0 = hold all state, valido forced 0
//  entrada       in   1   serial data, MSB (word bit 9) first
//  salidas       out  10  last aligned word, first-received bit in [9]
//  valido        out  1   one-cycle pulse: salidas updated this cycle
//  sincronizado  out  1   1 while in LOCKED
//  estado        out  2   00 SEARCH, 01 ALIGN, 10 LOCKED
//  los           out  1   loss-of-sync pulse (port exists only with SP_LOS_EN)
// BEHAVIOUR
//  Reset (rst=0, async): sr=0, salidas=0, valido=0, bitcnt=0, estado=SEARCH, cntComma=0,
//    sincronizado=0, los=0, cntLos=0. Release is sampled on the next posedge.
//  Each posedge with enb=1:
//    nxt = {sr[8:0], entrada}; sr <= nxt
//    comma = (nxt==COMMA_P) | (nxt==COMMA_N)
//    boundary = (bitcnt==9)
//  bitcnt counts 0..9 and wraps 9->0. Any realignment forces bitcnt <= 0.
//  SEARCH: on comma -> salidas<=nxt, valido<=1, bitcnt<=0, cntComma<=1,
//    next state ALIGN, or LOCKED if COMMA_LOCK==1. Otherwise valido=0.
//  ALIGN: on boundary -> salidas<=nxt, valido<=1.
//    If comma, cntComma++; reaching COMMA_LOCK goes to LOCKED.
//    If not comma, go to SEARCH and set cntComma<=0.
//    A comma seen off a boundary realigns: bitcnt<=0, cntComma<=1, salidas<=nxt, valido<=1.
//  LOCKED: on every boundary -> salidas<=nxt, valido<=1; comma or data makes no difference.
//    Off-boundary comma without SP_LOS_EN: ignored, no realign.
//  Latency: last bit of a word sampled at edge N -> salidas/valido registered at edge N,
//    visible until edge N+1. valido is never high on two consecutive cycles except during a
//    realign immediately after a boundary word.
//  enb=0: sr, bitcnt, estado, counters and salidas all hold; valido=0.
//  Simultaneous boundary and comma in SEARCH: treated as a comma detect, so bitcnt<=0.
//  sincronizado = (estado==LOCKED), registered. estado 11 is unreachable; if it occurs,
//    next state is SEARCH.
// CONFIGURATION
//  SP_LOS_EN defined: in LOCKED, each off-boundary comma increments cntLos.
//    An aligned comma clears cntLos.
//    When cntLos reaches LOS_THRESH: estado<=ALIGN, realign to the offending comma
//      (bitcnt<=0, cntComma<=1), cntLos<=0, los<=1 for one cycle.
//  SP_LOS_EN undefined: no los port and no cntLos; LOCKED is left only by reset.
// TESTING
//  1 rst=0 for 3 clk, then rst=1 with entrada=0 for 20 clk
//    -> salidas=0, valido=0, estado=00, sincronizado=0.
//  2 Send 3x 0011111010 then 1101101100
//    -> valido on 3 comma words; estado 00->01->10 at end of 3rd comma; sincronizado=1;
//       4th word salidas=1101101100 with valido.
//  3 Send 4 junk bits, 3x 1100000101, then 1111100000 and 0000011111
//    -> alignment ignores the junk; after lock salidas=1111100000 then 0000011111,
//       exactly 10 clk apart.
//  4 In ALIGN after 1 comma, send aligned 1010010101 -> estado=00, cntComma=0, no lock.
//  5 Locked, hold enb=0 for 7 clk mid-word, then resume
//    -> words are unchanged; valido is 0 during the hold.
//  6 SP_LOS_EN: locked, inject 2 commas shifted by 3 bits
//    -> los pulses once, estado=01, next words are aligned to the new phase.
//    Without SP_LOS_EN the same stimulus keeps estado=10.

Source files
------------

// File: rtl/serial_paralelo.sv
// serial_paralelo: receive-side 10-bit deserializer with K28.5 comma alignment.
// The serial line is sampled one bit per clk, MSB (word bit 9) first.
// An aligned word is emitted every 10 bits once a comma has fixed the phase.
// LOCKED is entered after COMMA_LOCK consecutive aligned commas.
// Optional feature macro: SP_LOS_EN adds the los port and loss-of-sync detection.
// With SP_LOS_EN, LOS_THRESH off-phase commas while LOCKED force a realign.
module serial_paralelo #(
    parameter logic [9:0] COMMA_P    = 10'b0011111010,
    parameter logic [9:0] COMMA_N    = 10'b1100000101,
    parameter int         COMMA_LOCK = 3,
    parameter int         LOS_THRESH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enb,
    input  logic       entrada,
    output logic [9:0] salidas,
    output logic       valido,
    output logic       sincronizado,
    output logic [1:0] estado
`ifdef SP_LOS_EN
    ,
    output logic       los
`endif
);

    typedef enum logic [1:0] {
        SEARCH = 2'b00,
        ALIGN  = 2'b01,
        LOCKED = 2'b10
    } state_t;

    localparam logic [3:0] LOCK_N = 4'(COMMA_LOCK);

    // Only the 9 most recent bits need storing; the 10th comes straight from entrada.
    logic [8:0] sr_q, sr_d;
    logic [3:0] bitcnt_q, bitcnt_d;
    state_t     estado_q, estado_d;
    logic [2:0] cnt_comma_q, cnt_comma_d;
    logic [9:0] salidas_q, salidas_d;
    logic       valido_q, valido_d;
    logic       sinc_q, sinc_d;

`ifdef SP_LOS_EN
    localparam logic [3:0] LOS_N = 4'(LOS_THRESH);
    logic [2:0] cnt_los_q, cnt_los_d;
    logic       los_q, los_d;
`endif

    logic [9:0] nxt;
    logic       comma;
    logic       boundary;

    assign nxt      = {sr_q, entrada};
    assign comma    = (nxt == COMMA_P) || (nxt == COMMA_N);
    assign boundary = (bitcnt_q == 4'd9);

    // Next-state logic: alignment FSM, word assembly and comma counting.
    always_comb begin
        sr_d        = sr_q;
        bitcnt_d    = bitcnt_q;
        estado_d    = estado_q;
        cnt_comma_d = cnt_comma_q;
        salidas_d   = salidas_q;
        valido_d    = 1'b0;
`ifdef SP_LOS_EN
        cnt_los_d   = cnt_los_q;
        los_d       = 1'b0;
`endif
        if (enb) begin
            sr_d     = nxt[8:0];
            bitcnt_d = boundary ? 4'd0 : bitcnt_q + 4'd1;
            case (estado_q)
                SEARCH: begin
                    if (comma) begin
                        // A comma anywhere fixes the word phase, even on a boundary.
                        salidas_d   = nxt;
                        valido_d    = 1'b1;
                        bitcnt_d    = 4'd0;
                        cnt_comma_d = 3'd1;
                        estado_d    = (LOCK_N == 4'd1) ? LOCKED : ALIGN;
                    end
                end
                ALIGN: begin
                    if (boundary) begin
                        salidas_d = nxt;
                        valido_d  = 1'b1;
                        if (comma) begin
                            cnt_comma_d = cnt_comma_q + 3'd1;
                            if ({1'b0, cnt_comma_q} + 4'd1 >= LOCK_N) begin
                                estado_d = LOCKED;
                            end
                        end else begin
                            estado_d    = SEARCH;
                            cnt_comma_d = 3'd0;
                        end
                    end else if (comma) begin
                        // Comma on a new phase: restart the count on that phase.
                        salidas_d   = nxt;
                        valido_d    = 1'b1;
                        bitcnt_d    = 4'd0;
                        cnt_comma_d = 3'd1;
                        if (LOCK_N == 4'd1) begin
                            estado_d = LOCKED;
                        end
                    end
                end
                LOCKED: begin
                    if (boundary) begin
                        salidas_d = nxt;
                        valido_d  = 1'b1;
                    end
`ifdef SP_LOS_EN
                    if (boundary && comma) begin
                        cnt_los_d = 3'd0;
                    end else if (!boundary && comma) begin
                        if ({1'b0, cnt_los_q} + 4'd1 >= LOS_N) begin
                            // Too many off-phase commas: follow the new phase.
                            estado_d    = ALIGN;
                            salidas_d   = nxt;
                            valido_d    = 1'b1;
                            bitcnt_d    = 4'd0;
                            cnt_comma_d = 3'd1;
                            cnt_los_d   = 3'd0;
                            los_d       = 1'b1;
                        end else begin
                            cnt_los_d = cnt_los_q + 3'd1;
                        end
                    end
`endif
                end
                default: begin
                    estado_d    = SEARCH;
                    cnt_comma_d = 3'd0;
                end
            endcase
        end
        sinc_d = (estado_d == LOCKED);
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_q        <= '0;
            bitcnt_q    <= '0;
            estado_q    <= SEARCH;
            cnt_comma_q <= '0;
            salidas_q   <= '0;
            valido_q    <= 1'b0;
            sinc_q      <= 1'b0;
`ifdef SP_LOS_EN
            cnt_los_q   <= '0;
            los_q       <= 1'b0;
`endif
        end else begin
            sr_q        <= sr_d;
            bitcnt_q    <= bitcnt_d;
            estado_q    <= estado_d;
            cnt_comma_q <= cnt_comma_d;
            salidas_q   <= salidas_d;
            valido_q    <= valido_d;
            sinc_q      <= sinc_d;
`ifdef SP_LOS_EN
            cnt_los_q   <= cnt_los_d;
            los_q       <= los_d;
`endif
        end
    end

    assign salidas      = salidas_q;
    assign valido       = valido_q;
    assign sincronizado = sinc_q;
    assign estado       = estado_q;
`ifdef SP_LOS_EN
    assign los          = los_q;
`endif

endmodule

// File: tb/tb_serial_paralelo.sv
// Testbench for serial_paralelo: word-level vector table plus hand-written
// sequences for reset, enable hold and off-phase commas (SP_LOS_EN aware).
module tb_serial_paralelo;

    localparam logic [9:0] CP = 10'b0011111010;
    localparam logic [9:0] CN = 10'b1100000101;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enb = 1'b0;
    logic       entrada = 1'b0;
    logic [9:0] salidas;
    logic       valido;
    logic       sincronizado;
    logic [1:0] estado;
`ifdef SP_LOS_EN
    logic       los;
`endif

    int checks = 0;
    int failures = 0;

    serial_paralelo dut (
        .clk          (clk),
        .rst          (rst),
        .enb          (enb),
        .entrada      (entrada),
        .salidas      (salidas),
        .valido       (valido),
        .sincronizado (sincronizado),
        .estado       (estado)
`ifdef SP_LOS_EN
        ,
        .los          (los)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_first;
        logic [9:0] word;
        int         nbits;
        logic       exp_v;
        logic [9:0] exp_s;
        logic [1:0] exp_e;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Drive one bit, let one rising edge pass, then sample 1 time unit later.
    task automatic bit_step(input logic e, input logic en);
        entrada = e;
        enb     = en;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        enb = 1'b1;
        entrada = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_salidas", 32'(salidas), 32'h0);
        chk("rst_valido", 32'(valido), 32'h0);
        chk("rst_estado", 32'(estado), 32'h0);
        chk("rst_sinc", 32'(sincronizado), 32'h0);
        rst = 1'b1;
    endtask

    task automatic send_word(input string name, input logic [9:0] word, input int nbits,
                             input logic exp_v, input logic [9:0] exp_s, input logic [1:0] exp_e);
        logic quiet_bad = 1'b0;
        for (int i = nbits - 1; i >= 0; i--) begin
            bit_step(word[i], 1'b1);
            if (i > 0 && valido !== 1'b0) quiet_bad = 1'b1;
        end
        $display("word %s bits=%0d valido=%b salidas=%b estado=%b sinc=%b",
                 name, nbits, valido, salidas, estado, sincronizado);
        if (nbits > 1) chk({name, "_quiet"}, 32'(quiet_bad), 32'h0);
        chk({name, "_valido"}, 32'(valido), 32'(exp_v));
        if (exp_v) chk({name, "_salidas"}, 32'(salidas), 32'(exp_s));
        chk({name, "_estado"}, 32'(estado), 32'(exp_e));
        chk({name, "_sinc"}, 32'(sincronizado), 32'(exp_e == 2'b10));
    endtask

    initial begin
        logic       bad;
        logic [22:0] seq;

        // Test 2: three RD- commas then data.
        vecs[0]  = '{1'b0, CP, 10, 1'b1, CP, 2'b01};
        vecs[1]  = '{1'b0, CP, 10, 1'b1, CP, 2'b01};
        vecs[2]  = '{1'b0, CP, 10, 1'b1, CP, 2'b10};
        vecs[3]  = '{1'b0, 10'b1101101100, 10, 1'b1, 10'b1101101100, 2'b10};
        // Test 3: 4 junk bits, three RD+ commas, two data words.
        vecs[4]  = '{1'b1, 10'b0000001010, 4, 1'b0, 10'b0, 2'b00};
        vecs[5]  = '{1'b0, CN, 10, 1'b1, CN, 2'b01};
        vecs[6]  = '{1'b0, CN, 10, 1'b1, CN, 2'b01};
        vecs[7]  = '{1'b0, CN, 10, 1'b1, CN, 2'b10};
        vecs[8]  = '{1'b0, 10'b1111100000, 10, 1'b1, 10'b1111100000, 2'b10};
        vecs[9]  = '{1'b0, 10'b0000011111, 10, 1'b1, 10'b0000011111, 2'b10};
        // Test 4: aligned non-comma in ALIGN drops to SEARCH and clears the count.
        vecs[10] = '{1'b1, CP, 10, 1'b1, CP, 2'b01};
        vecs[11] = '{1'b0, 10'b1010010101, 10, 1'b1, 10'b1010010101, 2'b00};
        vecs[12] = '{1'b0, CP, 10, 1'b1, CP, 2'b01};
        vecs[13] = '{1'b0, CP, 10, 1'b1, CP, 2'b01};
        vecs[14] = '{1'b0, CP, 10, 1'b1, CP, 2'b10};

        // Test 1: reset then 20 idle zeros.
        do_reset();
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bit_step(1'b0, 1'b1);
            if (valido !== 1'b0) bad = 1'b1;
        end
        $display("idle 20 bits: salidas=%b valido=%b estado=%b", salidas, valido, estado);
        chk("idle_valido_quiet", 32'(bad), 32'h0);
        chk("idle_salidas", 32'(salidas), 32'h0);
        chk("idle_estado", 32'(estado), 32'h0);
        chk("idle_sinc", 32'(sincronizado), 32'h0);

        // Tests 2-4 from the table.
        for (int v = 0; v < 15; v++) begin
            if (vecs[v].rst_first) do_reset();
            send_word($sformatf("vec%0d", v), vecs[v].word, vecs[v].nbits,
                      vecs[v].exp_v, vecs[v].exp_s, vecs[v].exp_e);
        end

        // Test 5: locked, hold enb=0 for 7 clk mid-word with the line toggling.
        send_word("t5_head", 10'b0000001101, 4, 1'b0, 10'b0, 2'b10);
        bad = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bit_step(i[0], 1'b0);
            if (valido !== 1'b0) bad = 1'b1;
        end
        $display("hold 7 clk: salidas=%b valido=%b estado=%b", salidas, valido, estado);
        chk("hold_valido_quiet", 32'(bad), 32'h0);
        chk("hold_salidas", 32'(salidas), 32'(CP));
        chk("hold_estado", 32'(estado), 32'h2);
        send_word("t5_tail", 10'b0000101100, 6, 1'b1, 10'b1101101100, 2'b10);
        send_word("t5_next", 10'b0110001011, 10, 1'b1, 10'b0110001011, 2'b10);

        // Test 6: locked, then two commas shifted by 3 bits.
        do_reset();
        send_word("t6_c1", CP, 10, 1'b1, CP, 2'b01);
        send_word("t6_c2", CP, 10, 1'b1, CP, 2'b01);
        send_word("t6_c3", CP, 10, 1'b1, CP, 2'b10);
        seq = {3'b101, CP, CP};
        bad = 1'b0;
        for (int k = 1; k <= 23; k++) begin
            bit_step(seq[23 - k], 1'b1);
            if (k == 10) begin
                chk("t6_k10_valido", 32'(valido), 32'h1);
                chk("t6_k10_salidas", 32'(salidas), 32'h29F);   // 1010011111
            end
            if (k == 13) chk("t6_k13_valido", 32'(valido), 32'h0);
            if (k == 20) begin
                chk("t6_k20_valido", 32'(valido), 32'h1);
                chk("t6_k20_salidas", 32'(salidas), 32'h11F);   // 0100011111
            end
`ifdef SP_LOS_EN
            if (k < 23 && los !== 1'b0) bad = 1'b1;
`endif
        end
        $display("shifted commas: salidas=%b valido=%b estado=%b", salidas, valido, estado);
`ifdef SP_LOS_EN
        chk("t6_los_early_quiet", 32'(bad), 32'h0);
        chk("t6_los_pulse", 32'(los), 32'h1);
        chk("t6_estado_align", 32'(estado), 32'h1);
        bit_step(CP[9], 1'b1);
        chk("t6_los_one_cycle", 32'(los), 32'h0);
        send_word("t6_new1", CP, 9, 1'b1, CP, 2'b01);
        send_word("t6_new2", CP, 10, 1'b1, CP, 2'b10);
`else
        chk("t6_estado_locked", 32'(estado), 32'h2);
        chk("t6_sinc_locked", 32'(sincronizado), 32'h1);
        chk("t6_k23_valido", 32'(valido), 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
